timer_cmd_sender: RTL and testbench
===================================

// Module: timer_cmd_sender
// PURPOSE
//  Initiator side of the serial timer-command protocol. On a start request it
//  shifts a frame onto data: 4-bit sync pattern, then 4-bit delay, MSB first.
//  It then supervises the timer's counting/done outputs, returns a 1-cycle ack,
//  and reports success or timeout to the local controller.
//  Sits between the control logic and the pattern-triggered delay timer.
// PARAMETERS
//  PATTERN          4'b1101  sync pattern, sent MSB first
//  CYCLES_PER_UNIT  1000     timer clocks per delay unit; timer runs (delay+1)*this
//  START_TIMEOUT    8        max cycles from last delay bit to counting=1
//  DONE_MARGIN      16       extra cycles allowed beyond (delay+1)*CYCLES_PER_UNIT
//  CLR_TIMEOUT      2        max cycles after ack for done to drop
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high reset
//  start     in   1  request a command; sampled only in IDLE
//  delay_in  in   4  delay value; latched when start is accepted
//  counting  in   1  timer status: counting
//  done      in   1  timer status: done, held until ack
//  data      out  1  serial command line to timer (registered)
//  ack       out  1  acknowledge to timer (registered, 1-cycle pulse)
//  busy      out  1  high from start acceptance until result pulse
//  cmd_ok    out  1  1-cycle pulse: command completed and acknowledged
//  cmd_err   out  1  1-cycle pulse: protocol timeout
//  err_code  out  2  01 no counting, 10 done late, 11 done stuck; held to next start
// BEHAVIOUR
//  Reset, async: state=IDLE; data, ack, busy, cmd_ok, cmd_err = 0; err_code=00.
//  Reset mid-frame or mid-wait aborts at once. No result pulse is issued.
//  IDLE: data=0. start=1 at edge N: latch delay_in, busy=1, err_code=00,
//   go to SHIFT. Bit 0 (PATTERN[3]) is driven on data from edge N until N+1.
//  SHIFT: 8 bits, one per cycle, bit k held for exactly one cycle.
//   Order: PATTERN[3:0], then delay[3:0]. 3-bit index; no wrap.
//   After bit 7, data returns to 0 and stays 0 until the next frame.
//  WAIT_CNT: timer counter reset on entry. counting=1 -> WAIT_DONE.
//   done=1 (counting missed) -> ACK. Counter reaches START_TIMEOUT -> ERR, code 01.
//  WAIT_DONE: counter compares against (delay+1)*CYCLES_PER_UNIT+DONE_MARGIN.
//   Counter width is $clog2(16*CYCLES_PER_UNIT+DONE_MARGIN+1); no overflow.
//   done=1 -> ACK. Limit reached -> ERR, code 10.
//  ACK: ack=1 for exactly one cycle, then CLR.
//  CLR: done=0 within CLR_TIMEOUT cycles -> OK. Otherwise -> ERR, code 11.
//  OK: cmd_ok=1 for one cycle, busy=0, then IDLE.
//  ERR: cmd_err=1 for one cycle, busy=0, then IDLE.
//  start while busy is ignored, not queued. start held high in IDLE after a
//   result issues back-to-back frames. At least 1 IDLE cycle comes between frames.
//  ack is never high outside ACK. data is never high outside SHIFT.
//  delay_in changes after acceptance have no effect on the current frame.
// TESTING
//  Tie to the pattern-triggered timer (CYCLES_PER_UNIT=10) unless noted.
//  1 start, delay_in=1 -> data 1,1,0,1,0,0,0,1 on 8 consecutive cycles;
//    counting rises; done ~20 cycles later; ack 1 cycle; cmd_ok=1; busy=0.
//  2 delay_in=15 -> cmd_ok after ~160 timer cycles, no cmd_err; 0 -> ~10 cycles.
//  3 stub timer that never raises counting -> cmd_err at START_TIMEOUT cycles
//    after bit 7; err_code=01; ack never asserted.
//  4 stub timer, counting only, never done -> cmd_err, err_code=10, delay=2:
//    at exactly 3*10+16 cycles in WAIT_DONE.
//  5 stub holds done high after ack -> cmd_err, err_code=11; ack width 1.
//  6 reset pulsed during bit 5 of the frame -> data=0, busy=0 immediately.
//    start pulsed while busy is ignored. A fresh start completes with cmd_ok.

Source files
------------

// File: rtl/timer_cmd_sender.sv
// timer_cmd_sender: serial command initiator for the pattern-triggered delay timer
//  clk, reset         clock and async active-high reset
//  start, delay_in    command request and its 4-bit delay value
//  counting, done     timer status inputs
//  data, ack          serial frame line and 1-cycle acknowledge to the timer
//  busy, cmd_ok, cmd_err, err_code  status reported to the local controller
module timer_cmd_sender #(
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter int CYCLES_PER_UNIT = 1000,
  parameter int START_TIMEOUT = 8,
  parameter int DONE_MARGIN = 16,
  parameter int CLR_TIMEOUT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] delay_in,
  input  logic       counting,
  input  logic       done,
  output logic       data,
  output logic       ack,
  output logic       busy,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [1:0] err_code
);
  localparam int CW = $clog2(16 * CYCLES_PER_UNIT + DONE_MARGIN + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_CNT, WAIT_DONE, ACK, CLR, OK, ERR} state_t;
  state_t state, next;
  logic [3:0] delay;
  logic [6:0] sh;
  logic [2:0] idx;
  logic [CW-1:0] cnt, lim;
  logic [1:0] code_d;
  logic data_d, accept;
  assign accept = state == IDLE && start;
  // compared against the counter value one cycle before the limit is reached
  assign lim = CW'((int'(delay) + 1) * CYCLES_PER_UNIT + DONE_MARGIN - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      delay <= '0;
      sh <= '0;
      idx <= '0;
      cnt <= '0;
      data <= 1'b0;
      ack <= 1'b0;
      busy <= 1'b0;
      cmd_ok <= 1'b0;
      cmd_err <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= next;
      delay <= accept ? delay_in : delay;
      sh <= accept ? {PATTERN[2:0], delay_in} : sh << 1;
      idx <= (state == SHIFT && idx != 3'd7) ? idx + 3'd1 : 3'd0;
      // restarts on every state change so each wait phase times itself
      cnt <= (next != state || state == IDLE) ? '0 : cnt + CW'(1);
      data <= data_d;
      ack <= next == ACK;
      busy <= !(next inside {IDLE, OK, ERR});
      cmd_ok <= next == OK;
      cmd_err <= next == ERR;
      err_code <= code_d;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = start ? SHIFT : IDLE;
      SHIFT:     next = idx == 3'd7 ? WAIT_CNT : SHIFT;
      WAIT_CNT:  next = counting ? WAIT_DONE : done ? ACK : cnt == CW'(START_TIMEOUT - 1) ? ERR : WAIT_CNT;
      WAIT_DONE: next = done ? ACK : cnt == lim ? ERR : WAIT_DONE;
      ACK:       next = CLR;
      CLR:       next = !done ? OK : cnt == CW'(CLR_TIMEOUT - 1) ? ERR : CLR;
      default:   next = IDLE;
    endcase
  end
  always_comb begin
    // bit 0 goes out on the accepting edge; sh[6] always holds the next bit
    data_d = accept ? PATTERN[3] : (state == SHIFT && idx != 3'd7) ? sh[6] : 1'b0;
    code_d = accept ? 2'b00 : next != ERR ? err_code : state == WAIT_CNT ? 2'b01 : state == WAIT_DONE ? 2'b10 : 2'b11;
  end
endmodule

// File: tb/tb_timer_cmd_sender.sv
// tb_timer_cmd_sender: directed bench with a behavioural timer responder
module tb_timer_cmd_sender;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] delay_in = '0;
  logic counting, done, data, ack, busy, cmd_ok, cmd_err;
  logic [1:0] err_code;
  int n_chk = 0, n_err = 0, mode = 0, tst, tcnt;
  logic [7:0] sr, fr;
  int cyc, acks, dh;
  logic ok, err;
  always #5 clk = ~clk;
  timer_cmd_sender #(.CYCLES_PER_UNIT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .delay_in(delay_in),
    .counting(counting), .done(done), .data(data), .ack(ack), .busy(busy),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
  );
  // mode 0 normal timer, 1 never counts, 2 counts forever, 3 done stuck after ack
  always @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0; tst <= 0; tcnt <= 0; counting <= 1'b0; done <= 1'b0;
    end else begin
      sr <= {sr[6:0], data};
      case (tst)
        0: if (mode != 1 && sr[6:3] == 4'b1101) begin
          tst <= 1; counting <= 1'b1; tcnt <= (int'({sr[2:0], data}) + 1) * 10;
        end
        1: if (mode != 2) begin
          if (tcnt == 1) begin counting <= 1'b0; done <= 1'b1; tst <= 2; end
          else tcnt <= tcnt - 1;
        end
        default: if (ack && mode != 3) begin done <= 1'b0; tst <= 0; end
      endcase
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset(input int m);
    @(negedge clk); reset = 1'b1; mode = m;
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic run_frame(input logic [3:0] d, input bit ign);
    @(negedge clk); start = 1'b1; delay_in = d;
    @(negedge clk); start = 1'b0; delay_in = ~d;
    check("busy_on", busy, 1);
    check("code_clr", err_code, 0);
    fr = {7'b0, data};
    for (int i = 1; i < 8; i++) begin @(negedge clk); fr = {fr[6:0], data}; end
    cyc = 0; acks = 0; dh = 0;
    do begin
      @(negedge clk); cyc++;
      start = ign && cyc == 3;
      acks += int'(ack); dh += int'(data);
    end while (!(cmd_ok || cmd_err) && cyc < 400);
    ok = cmd_ok; err = cmd_err; start = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_ok", cmd_ok, 0);
    check("rst_err", cmd_err, 0);
    check("rst_code", err_code, 0);
    reset = 1'b0;
    run_frame(4'd1, 0);
    check("d1_frame", fr, 8'hD1); check("d1_cyc", cyc, 24); check("d1_ack", acks, 1);
    check("d1_ok", ok, 1); check("d1_err", err, 0); check("d1_data_idle", dh, 0);
    @(negedge clk);
    check("d1_busy_off", busy, 0); check("d1_ok_pulse", cmd_ok, 0);
    run_frame(4'd15, 0);
    check("d15_frame", fr, 8'hDF); check("d15_cyc", cyc, 164); check("d15_ok", ok, 1); check("d15_err", err, 0);
    run_frame(4'd0, 0);
    check("d0_frame", fr, 8'hD0); check("d0_cyc", cyc, 14); check("d0_ok", ok, 1);
    do_reset(1);
    run_frame(4'd1, 0);
    check("nocnt_cyc", cyc, 9); check("nocnt_err", err, 1); check("nocnt_ack", acks, 0); check("nocnt_code", err_code, 1);
    do_reset(2);
    run_frame(4'd2, 0);
    check("late_cyc", cyc, 48); check("late_err", err, 1); check("late_code", err_code, 2); check("late_ack", acks, 0);
    do_reset(3);
    run_frame(4'd1, 0);
    check("stuck_cyc", cyc, 25); check("stuck_err", err, 1); check("stuck_ack", acks, 1); check("stuck_code", err_code, 3);
    @(negedge clk);
    check("stuck_code_held", err_code, 3); check("stuck_err_pulse", cmd_err, 0);
    do_reset(0);
    @(negedge clk); start = 1'b1; delay_in = 4'b0100;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_bit5", data, 1); check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_data", data, 0); check("abort_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    run_frame(4'd1, 1);
    check("ign_frame", fr, 8'hD1); check("ign_cyc", cyc, 24); check("ign_ok", ok, 1);
    repeat (3) @(negedge clk);
    check("ign_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
